// File: rtl/led_bank_pkg.sv
// rtl/led_bank_pkg.sv - shared register offsets and defaults for the LED bank controller
package led_bank_pkg;

    localparam int LED_NUM_LEDS_DEF = 16;

    localparam logic [2:0] LED_A_ON     = 3'd0;
    localparam logic [2:0] LED_A_MASK   = 3'd1;
    localparam logic [2:0] LED_A_HP     = 3'd2;
    localparam logic [2:0] LED_A_SET    = 3'd3;
    localparam logic [2:0] LED_A_CLR    = 3'd4;
    localparam logic [2:0] LED_A_TGL    = 3'd5;
    localparam logic [2:0] LED_A_BRIGHT = 3'd6;
    localparam logic [2:0] LED_A_RSVD   = 3'd7;

endpackage

// File: rtl/led_bank_ctrl_if.sv
// rtl/led_bank_ctrl_if.sv - store-path register bus into the LED region
interface led_bank_ctrl_if;

    logic [2:0]  A;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;

    modport master (output A, output WD, output WE, input RD);
    modport slave  (input A, input WD, input WE, output RD);

endinterface

// File: rtl/led_timebase.sv
// rtl/led_timebase.sv - prescaler tick, blink half-period counter and blink phase
module led_timebase #(
    parameter int PRESCALE = 50000,
    parameter int BLINK_W  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_restart,
    input  logic [BLINK_W-1:0] i_hp,
    output logic               o_tick,
    output logic               o_phase
);

    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]   r_pre_cnt;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_phase;
    logic [BLINK_W-1:0] w_hp_last;

    assign o_tick  = (r_pre_cnt == PRE_LAST);
    assign o_phase = r_phase;

    // A zero half-period behaves like one tick, so the last count is 0 either way
    assign w_hp_last = (i_hp == '0) ? '0 : i_hp - BLINK_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre_cnt <= '0;
        end else if (o_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + PRE_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (i_restart) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (o_tick) begin
            if (r_blink_cnt == w_hp_last) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_bank_ctrl.sv
// rtl/led_bank_ctrl.sv - memory-mapped LED bank: set/clr/toggle, blink, readback
// LED_BANK_PWM_EN adds the PWM counter and BRIGHT register; otherwise LEDs run at full on.
module led_bank_ctrl
    import led_bank_pkg::*;
#(
    parameter int NUM_LEDS  = LED_NUM_LEDS_DEF,
    parameter int PRESCALE  = 50000,
    parameter int BLINK_W   = 16,
    parameter int BLINK_RST = 500,
    parameter int PWM_BITS  = 8
) (
    input  logic                CLK,
    input  logic                ResetN,
    led_bank_ctrl_if.slave      bus,
    output logic [NUM_LEDS-1:0] LED
);

    logic [NUM_LEDS-1:0] r_on;
    logic [NUM_LEDS-1:0] r_mask;
    logic [BLINK_W-1:0]  r_hp;
    logic [NUM_LEDS-1:0] r_led;
    logic [NUM_LEDS-1:0] w_wd_leds;
    logic [PWM_BITS-1:0] w_bright;
    logic [31:0]         w_rd;
    logic                w_hp_wr;
    logic                w_tick;
    logic                w_phase;
    logic                w_pwm_on;
    logic                w_unused;

    assign w_wd_leds = bus.WD[NUM_LEDS-1:0];
    assign w_hp_wr   = bus.WE && (bus.A == LED_A_HP);
    assign w_unused  = ^{bus.WD, w_tick};

    led_timebase #(
        .PRESCALE (PRESCALE),
        .BLINK_W  (BLINK_W)
    ) u_timebase (
        .i_clk     (CLK),
        .i_rst_n   (ResetN),
        .i_restart (w_hp_wr),
        .i_hp      (r_hp),
        .o_tick    (w_tick),
        .o_phase   (w_phase)
    );

    // SET/CLR/TGL are read-modify-write on the value held before this edge
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            r_on   <= '0;
            r_mask <= '0;
            r_hp   <= BLINK_W'(BLINK_RST);
        end else if (bus.WE) begin
            case (bus.A)
                LED_A_ON:   r_on   <= w_wd_leds;
                LED_A_MASK: r_mask <= w_wd_leds;
                LED_A_HP:   r_hp   <= bus.WD[BLINK_W-1:0];
                LED_A_SET:  r_on   <= r_on | w_wd_leds;
                LED_A_CLR:  r_on   <= r_on & ~w_wd_leds;
                LED_A_TGL:  r_on   <= r_on ^ w_wd_leds;
                default:    ;
            endcase
        end
    end

`ifdef LED_BANK_PWM_EN
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_bright;

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            r_pwm_cnt <= '0;
            r_bright  <= '1;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            if (bus.WE && (bus.A == LED_A_BRIGHT)) begin
                r_bright <= bus.WD[PWM_BITS-1:0];
            end
        end
    end

    assign w_pwm_on = (r_pwm_cnt <= r_bright);
    assign w_bright = r_bright;
`else
    assign w_pwm_on = 1'b1;
    assign w_bright = '1;
`endif

    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            r_led <= '0;
        end else begin
            r_led <= r_on & (~r_mask | {NUM_LEDS{w_phase}}) & {NUM_LEDS{w_pwm_on}};
        end
    end

    assign LED = r_led;

    always_comb begin
        w_rd = '0;
        case (bus.A)
            LED_A_ON, LED_A_SET, LED_A_CLR, LED_A_TGL: w_rd[NUM_LEDS-1:0] = r_on;
            LED_A_MASK:   w_rd[NUM_LEDS-1:0] = r_mask;
            LED_A_HP:     w_rd[BLINK_W-1:0]  = r_hp;
            LED_A_BRIGHT: w_rd[PWM_BITS-1:0] = w_bright;
            default:      ;
        endcase
    end

    assign bus.RD = w_rd;

endmodule
